// File: rtl/nios2_oci_trace_pkg.sv
// Shared types and helpers for the OCI trace capture buffer.
package nios2_oci_trace_pkg;

  typedef enum logic [2:0] {
    ST_CAPTURE,
    ST_POST,
    ST_FROZEN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Default geometry; the top recomputes these from its own parameters.
  localparam int DEF_DCT_W  = 30;
  localparam int DEF_SLOT_W = 2;
  localparam int DEF_DEPTH  = 64;
  localparam int DCT_SLOTS  = DEF_DCT_W / DEF_SLOT_W;
  localparam int PTR_W      = $clog2(DEF_DEPTH);

  // Widest trace word the mask helper can describe.
  localparam int MASK_MAX   = 256;

  // Ones over the low count*slot_w bits: keeps valid slots, zeroes the rest.
  function automatic logic [MASK_MAX-1:0] slot_mask(input int count, input int slot_w);
    logic [MASK_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_MAX; i++) m[i] = (i < count * slot_w);
    return m;
  endfunction

endpackage

// File: rtl/nios2_oci_trace_ram.sv
// Simple dual-port capture memory, registered read, no array reset.
module nios2_oci_trace_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int W     = 34
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_q;

  // Write port.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read port; output holds while i_re is low so a stalled beat stays put.
  always_ff @(posedge i_clk) begin
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;
endmodule

// File: rtl/nios2_oci_trace_capture.sv
// Captures DCT words into a circular buffer, freezes after a post-trigger
// window, then drains the history oldest-first over a valid/ready stream.
module nios2_oci_trace_capture
  import nios2_oci_trace_pkg::*;
#(
  parameter int DCT_W     = 30,
  parameter int SLOT_W    = 2,
  parameter int CNT_W     = 4,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 8,
  parameter int WRAP_MODE = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [DCT_W-1:0] i_dct_buffer,
  input  logic [CNT_W-1:0] i_dct_count,
  input  logic             i_dct_valid,
  input  logic             i_test_ending,
  input  logic             i_test_has_ended,
  output logic [DCT_W-1:0] o_rd_data,
  output logic [CNT_W-1:0] o_rd_count,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic             o_rd_last,
  output logic             o_done,
  output logic [15:0]      o_dropped,
  output logic             o_count_err
);
  localparam int N_SLOTS = DCT_W / SLOT_W;
  localparam int AW      = $clog2(DEPTH);
  localparam int EW      = CNT_W + DCT_W;
  localparam int PW      = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t           r_state;
  logic             r_end_d, r_hend_d;
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_fill, r_rd_cnt;
  logic [PW-1:0]    r_post_cnt;
  logic [15:0]      r_dropped;
  logic             r_count_err, r_vld, r_last, r_done;

  logic             w_end_rise, w_hend_rise, w_acc, w_over, w_capt, w_full;
  logic             w_we, w_adv, w_re, w_to_drain;
  logic [CNT_W-1:0] w_cnt;
  logic [DCT_W-1:0] w_mask;
  logic [EW-1:0]    w_wdata, w_q;
  logic [AW-1:0]    w_wr_ptr_nxt;
  logic [AW:0]      w_fill_nxt;

  assign w_end_rise  = i_test_ending & ~r_end_d;
  assign w_hend_rise = i_test_has_ended & ~r_hend_d;
  assign w_acc       = i_dct_valid && (i_dct_count != '0);
  assign w_over      = i_dct_count > CNT_W'(N_SLOTS);
  assign w_cnt       = w_over ? CNT_W'(N_SLOTS) : i_dct_count;
  assign w_mask      = DCT_W'(slot_mask(int'(w_cnt), SLOT_W));
  assign w_wdata     = {w_cnt, i_dct_buffer & w_mask};
  assign w_capt      = w_acc && (r_state == ST_CAPTURE || r_state == ST_POST);
  assign w_full      = (r_fill == FULL);
  // In stop-on-full mode a full buffer turns captures into drops.
  assign w_we        = w_capt && (WRAP_MODE != 0 || !w_full);
  assign w_wr_ptr_nxt = w_we ? r_wr_ptr + 1'b1 : r_wr_ptr;
  assign w_fill_nxt  = (w_we && !w_full) ? r_fill + 1'b1 : r_fill;
  assign w_to_drain  = w_hend_rise &&
                       (r_state == ST_CAPTURE || r_state == ST_POST || r_state == ST_FROZEN);
  // Output slot is free when empty or its beat is being taken this cycle.
  assign w_adv       = !r_vld || i_rd_ready;
  assign w_re        = (r_state == ST_DRAIN) && w_adv && (r_rd_cnt != r_fill);

  nios2_oci_trace_ram #(.DEPTH(DEPTH), .AW(AW), .W(EW)) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_q)
  );

  // Capture/drain control, pointers and status.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_CAPTURE;
      r_end_d     <= 1'b0;
      r_hend_d    <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_rd_cnt    <= '0;
      r_post_cnt  <= '0;
      r_dropped   <= '0;
      r_count_err <= 1'b0;
      r_vld       <= 1'b0;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_end_d  <= i_test_ending;
      r_hend_d <= i_test_has_ended;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_fill   <= w_fill_nxt;
      r_done   <= 1'b0;
      if (w_capt && w_over) r_count_err <= 1'b1;
      if (w_capt && !w_we && r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;

      if (w_to_drain) begin
        r_state <= ST_DRAIN;
      end else begin
        case (r_state)
          ST_CAPTURE: if (w_end_rise) begin
            if (POST_TRIG == 0) r_state <= ST_FROZEN;
            else begin
              r_state    <= ST_POST;
              r_post_cnt <= PW'(POST_TRIG);
            end
          end
          ST_POST: if (w_capt) begin
            r_post_cnt <= r_post_cnt - 1'b1;
            if (r_post_cnt == PW'(1)) r_state <= ST_FROZEN;
          end
          ST_DRAIN: if (r_fill == '0 || (r_vld && r_last && i_rd_ready)) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
          default: ;
        endcase
      end

      // Oldest entry sits at wr_ptr once the buffer has wrapped, else at 0;
      // use next-state values so a word written on the trigger cycle counts.
      if (w_to_drain) begin
        r_rd_ptr <= (w_fill_nxt == FULL) ? w_wr_ptr_nxt : '0;
        r_rd_cnt <= '0;
      end else if (w_re) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end

      if (w_adv) begin
        r_vld  <= w_re;
        r_last <= w_re && (r_rd_cnt == r_fill - 1'b1);
      end
    end
  end

  assign o_rd_valid  = r_vld;
  assign o_rd_last   = r_vld & r_last;
  assign o_rd_data   = r_vld ? w_q[DCT_W-1:0] : '0;
  assign o_rd_count  = r_vld ? w_q[EW-1:DCT_W] : '0;
  assign o_done      = r_done;
  assign o_dropped   = r_dropped;
  assign o_count_err = r_count_err;
endmodule
